// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer:
// funct3 op codes, FSM states, iteration count and alu function codes.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam int MULDIV_ITER = 32;
  localparam int CNT_W       = $clog2(MULDIV_ITER);

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_LOOP,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_is_mulh(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu.sv
// Execute-stage 32-bit integer alu; fn[3] selects the subtract / arithmetic
// variant of the add and shift-right functions.
module alu (
  input  logic [3:0]  fn,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (fn)
      4'h0:    result = x + y;
      4'h8:    result = x - y;
      4'h1:    result = x << y[4:0];
      4'h2:    result = {31'b0, ($signed(x) < $signed(y))};
      4'h3:    result = {31'b0, (x < y)};
      4'h4:    result = x ^ y;
      4'h5:    result = x >> y[4:0];
      4'hd:    result = $signed(x) >>> y[4:0];
      4'h6:    result = x | y;
      4'h7:    result = x & y;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sharing one alu for every add/subtract.
// Define MULDIV_DIV_EN to build the divide/remainder datapath; otherwise ops 4-7 return rsp_err.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  state_t           state;
  logic [2:0]       op;
  logic [XLEN-1:0]  a_val;
  logic [XLEN-1:0]  b_val;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       alu_fn;
  logic [XLEN-1:0]  alu_x;
  logic [XLEN-1:0]  alu_y;
  logic [XLEN-1:0]  alu_res;
  logic             unused_zero;

  alu u_alu (
    .fn     (alu_fn),
    .x      (alu_x),
    .y      (alu_y),
    .result (alu_res),
    .zero   (unused_zero)
  );

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] div_shift;
  logic            div_borrow;
  logic            div_zero;
  logic            div_ovf;

  // Remainder is {hi, lo[31]} shifted left; hi[31] acts as the 33rd bit.
  assign div_shift  = {hi[XLEN-2:0], lo[XLEN-1]};
  assign div_borrow = !hi[XLEN-1] && (div_shift < b_val);
  assign div_zero   = (b_val == '0);
  // a_val still holds the raw dividend during PREP.
  assign div_ovf    = (op == OP_DIV || op == OP_REM) && b_neg && (b_val == XLEN'(1))
                      && (a_val == {1'b1, {(XLEN-1){1'b0}}});
`endif

  always_comb begin
    alu_fn = FN_ADD;
    alu_x  = '0;
    alu_y  = '0;
    case (state)
      ST_IDLE: begin
        alu_fn = FN_SUB;
        alu_y  = req_b;
      end
      ST_PREP: begin
        alu_fn = FN_SUB;
        alu_y  = a_val;
      end
      ST_LOOP: begin
`ifdef MULDIV_DIV_EN
        if (op_is_div(op)) begin
          alu_fn = FN_SUB;
          alu_x  = div_shift;
          alu_y  = b_val;
        end else
`endif
        begin
          alu_fn = FN_ADD;
          alu_x  = hi;
          alu_y  = a_val;
        end
      end
      ST_FIX: begin
        alu_fn = FN_SUB;
        alu_y  = (op_is_mulh(op) || op_is_rem(op)) ? hi : lo;
      end
      default: ;
    endcase
  end

  logic            mul_carry;
  logic [XLEN-1:0] mul_hi_next;
  logic [XLEN-1:0] mul_lo_next;

  always_comb begin
    mul_carry   = 1'b0;
    mul_hi_next = {1'b0, hi[XLEN-1:1]};
    mul_lo_next = {hi[0], lo[XLEN-1:1]};
    if (lo[0]) begin
      mul_carry   = (alu_res < a_val);
      mul_hi_next = {mul_carry, alu_res[XLEN-1:1]};
      mul_lo_next = {alu_res[0], lo[XLEN-1:1]};
    end
  end

  // Negate only the selected word; the high word of a negated 64-bit product
  // takes the borrow from the low word, so it is ~hi unless lo is zero.
  logic            res_neg;
  logic [XLEN-1:0] fix_result;

  always_comb begin
    res_neg    = a_neg ^ b_neg;
    fix_result = lo;
    if (op == OP_MUL) begin
      fix_result = res_neg ? alu_res : lo;
    end else if (op_is_mulh(op)) begin
      fix_result = !res_neg ? hi : ((lo == '0) ? alu_res : ~hi);
    end
`ifdef MULDIV_DIV_EN
    else if (op_is_rem(op)) begin
      fix_result = a_neg ? alu_res : hi;
    end else begin
      fix_result = res_neg ? alu_res : lo;
    end
`endif
  end

`ifdef MULDIV_DIV_EN
  assign rsp_err = 1'b0;
`else
  logic err;
  assign rsp_err = err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      op        <= OP_MUL;
      a_val     <= '0;
      b_val     <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
`ifndef MULDIV_DIV_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op        <= req_op;
            a_val     <= req_a;
            a_neg     <= op_a_signed(req_op) && req_a[XLEN-1];
            b_neg     <= op_b_signed(req_op) && req_b[XLEN-1];
            b_val     <= (op_b_signed(req_op) && req_b[XLEN-1]) ? alu_res : req_b;
            req_ready <= 1'b0;
            state     <= ST_PREP;
          end
        end
        ST_PREP: begin
          if (a_neg) begin
            a_val <= alu_res;
          end
          hi    <= '0;
          lo    <= op_is_div(op) ? (a_neg ? alu_res : a_val) : b_val;
          cnt   <= CNT_W'(MULDIV_ITER - 1);
          state <= ST_LOOP;
`ifdef MULDIV_DIV_EN
          if (op_is_div(op) && (div_zero || div_ovf)) begin
            state     <= ST_DONE;
            rsp_valid <= 1'b1;
            if (div_zero) begin
              rsp_data <= op_is_rem(op) ? a_val : '1;
            end else begin
              rsp_data <= op_is_rem(op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
          end
`else
          err <= 1'b0;
          if (op_is_div(op)) begin
            state     <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            err       <= 1'b1;
          end
`endif
        end
        ST_LOOP: begin
`ifdef MULDIV_DIV_EN
          if (op_is_div(op)) begin
            hi <= div_borrow ? div_shift : alu_res;
            lo <= {lo[XLEN-2:0], !div_borrow};
          end else
`endif
          begin
            hi <= mul_hi_next;
            lo <= mul_lo_next;
          end
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          rsp_data  <= fix_result;
          rsp_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases plus random ops against
// an arithmetic reference model; expectations follow MULDIV_DIV_EN when defined.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from 64-bit arithmetic; lat counts edges from the accept edge.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic e, output int lat);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    e   = 1'b0;
    lat = 35;
    d   = '0;
`ifndef MULDIV_DIV_EN
    if (op >= 3'd4) begin
      e   = 1'b1;
      lat = 2;
      return;
    end
`endif
    case (op)
      3'd0: begin p = sa * sb; d = p[31:0]; end
      3'd1: begin p = sa * sb; d = p[63:32]; end
      3'd2: begin p = sa * ub; d = p[63:32]; end
      3'd3: begin p = ua * ub; d = p[63:32]; end
      3'd4: begin
        if (b == 0) begin d = 32'hFFFF_FFFF; lat = 2; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin d = 32'h8000_0000; lat = 2; end
        else begin p = sa / sb; d = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) begin d = 32'hFFFF_FFFF; lat = 2; end
        else d = a / b;
      end
      3'd6: begin
        if (b == 0) begin d = a; lat = 2; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin d = 32'h0; lat = 2; end
        else begin p = sa % sb; d = p[31:0]; end
      end
      default: begin
        if (b == 0) begin d = a; lat = 2; end
        else d = a % b;
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          n;
    model(op, a, b, exp_d, exp_e, exp_lat);
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = $urandom();
    req_b     = $urandom();
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk($sformatf("latency_op%0d", op), 32'(n), 32'(exp_lat));
    chk($sformatf("data_op%0d_%h_%h", op, a, b), rsp_data, exp_d);
    chk($sformatf("err_op%0d", op), 32'(rsp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        req_valid = 1'b1;
        req_op    = OP_MUL;
        req_a     = 32'd5;
        req_b     = 32'd5;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", rsp_data, exp_d);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after_done_req_ready", 32'(req_ready), 32'd1);
    chk("after_done_rsp_valid", 32'(rsp_valid), 32'd0);
    $display("op=%0d a=%h b=%h data=%h err=%0d edges=%0d hold=%0d", op, a, b, exp_d, exp_e, n, hold);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int seen;
    int hold;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_MUL, 32'd7, 32'd6, 0);
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MUL, 32'hFFFF_FFF9, 32'd6, 0);

    // Back-pressure in DONE with a stray request pulse
    run_op(OP_MUL, 32'd7, 32'd6, 5);

    // Asynchronous reset during LOOP iteration 10
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_MUL;
    req_a     = 32'h1234;
    req_b     = 32'h5678;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midloop_rst_req_ready", 32'(req_ready), 32'd1);
    chk("midloop_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midloop_rst_rsp_data", rsp_data, 32'd0);
    chk("midloop_rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    run_op(OP_MUL, 32'd3, 32'd3, 0);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 0);
    run_op(OP_REMU, 32'd100, 32'd7, 0);
    run_op(OP_DIVU, 32'd5, 32'd0, 0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV, 32'd10, 32'd2, 0);
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, 2);
    run_op(OP_MUL, 32'd7, 32'd6, 0);

    for (int k = 0; k < 48; k++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = pick_operand();
      rb   = pick_operand();
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(rop, ra, rb, hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
